voice_envelope: RTL
===================

# voice_envelope

ADSR envelope generator and amplitude gate that sits directly downstream of the pulse oscillator `voice`. It consumes the oscillator's 1-bit waveform and a note gate, and produces an unsigned amplitude sample for the mixer/DAC stage. The block runs on the same sample-enable strobe as the oscillator. Envelope rates and the sustain level are per-voice register inputs.

## Interface
Parameters:
- `ENV_WIDTH`, default 8: envelope level and sample width.
- `RATE_SHIFT`, default 4: step period = (rate+1) << RATE_SHIFT en-cycles.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `en` in 1: sample enable, the same strobe that drives `voice`. All state advances only on cycles where `en`=1.
- `gate` in 1: note on (1) / note off (0).
- `attack` in 4: attack rate, 0 = fastest.
- `decay` in 4: decay rate.
- `sustain` in 4: sustain level. Expanded to `ENV_WIDTH` by replication, so 4'hA → 8'hAA.
- `release` in 4: release rate.
- `voice_in` in 1: waveform bit from the oscillator.
- `env_level` out `ENV_WIDTH`: current envelope level (register).
- `sample_out` out `ENV_WIDTH`: gated amplitude sample (register).
- `active` out 1: 1 whenever state ≠ IDLE (combinational from the state register).

## Operation
- **States:** IDLE, ATTACK, DECAY, SUSTAIN, RELEASE. MAX = all-ones at `ENV_WIDTH`. SUS = replicated `sustain`.
- **Gate sampling:** `gate_q` is updated only on en cycles.
  - Rising edge = `gate`=1 and `gate_q`=0 on an en cycle.
  - Falling edge = `gate`=0 and `gate_q`=1 on an en cycle.
- **Edge priority:** edges take priority over steps.
  - Rising edge, any state → ATTACK. Level is unchanged (retrigger from the current level).
  - Falling edge, any state except IDLE → RELEASE.
- **Prescaler:** counts en cycles in ATTACK, DECAY and RELEASE.
  - A step fires when the count equals period−1; the count then returns to 0.
  - Period uses the rate of the current state.
  - The counter is cleared on every state change and held at 0 in IDLE and SUSTAIN.
  - Counter width is 4+`RATE_SHIFT`.
- **ATTACK step:**
  - If level = MAX → DECAY with no change.
  - Otherwise level+1; if the result is MAX → DECAY in the same cycle.
- **DECAY step:**
  - If level ≤ SUS → SUSTAIN with no change.
  - Otherwise level−1; if the result equals SUS → SUSTAIN.
- **SUSTAIN:** level held. Changing `sustain` here has no effect until the next DECAY.
- **RELEASE step:**
  - If level = 0 → IDLE.
  - Otherwise level−1; if the result is 0 → IDLE.
- **IDLE:** level stays 0.
- **Arithmetic:** level never wraps. It saturates at 0 and MAX by the rules above.
- **Rate changes:** a rate change mid-state takes effect at the next comparison. If the count is already ≥ the new period−1, the step fires on the next en cycle.

## Timing
- **Reset values:** state IDLE, `env_level`=0, `sample_out`=0, `active`=0, prescaler 0, `gate_q`=0.
- **Reset mid-envelope:** reset takes effect on the next clk edge regardless of `en`.
- **No en:** with `en`=0, every register holds.
- **sample_out:** on an en cycle, `sample_out` <= `voice_in` ? `env_level` : 0. It uses the pre-update `env_level`, giving 1 en-cycle latency from `voice_in`.
- **Gate to state:** a gate edge sampled on en cycle N changes state at N+1. The first step lands at the end of en cycle N+period.
- **Single-edge rule:** rise and fall cannot coincide because only one `gate` sample is taken per en cycle.

## Structure
- **Package `voice_pkg`:**
  - State enum typedef (IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4, 3-bit).
  - `ENV_WIDTH` default.
  - `RATE_SHIFT` default.
- **Sub-module `env_prescaler`:**
  - Inputs: `en`, `clear`, `run`, 4-bit rate.
  - Output: 1-cycle `step`.
  - Instantiated once.
- **Top:** the FSM, level register and output register live in the top.

## Test plan
All scenarios use `RATE_SHIFT`=0 and `en`=1 every cycle unless stated.
- **Reset:** assert reset with `gate`=1 → `env_level`=0, `sample_out`=0, `active`=0 the cycle after reset; release reset and hold `gate`=1 → ATTACK (a rising edge is seen against `gate_q`=0).
- **Full ADSR:** attack=0, decay=1, sustain=8, release=0.
  - Rise → `env_level` reaches 0xFF 255 en-cycles after entering ATTACK.
  - Then decays one step per 2 en-cycles to 0x88 (238 cycles) and enters SUSTAIN.
  - Drop gate → reaches 0 after 136 en-cycles, then IDLE and `active`=0.
- **Early release:** drop gate at level 0x40 in ATTACK → RELEASE next cycle, descends from 0x40 to 0 with no overshoot.
- **Retrigger:** rising edge at level 0x50 during RELEASE → ATTACK starting from 0x50, not 0.
- **en gating:** `en` pulsed once every 3 clk → step timing scales to exactly 3× in clk cycles; nothing changes on non-en cycles.
- **Sample gating:** in SUSTAIN with level 0x88, toggle `voice_in` each en cycle → `sample_out` alternates 0x88/0x00, lagging `voice_in` by one en cycle.

Source files
------------

// File: rtl/voice_envelope_pkg.sv
// -----------------------------------------------------------------------------
// voice_pkg
// Shared definitions for the ADSR envelope generator: the envelope state
// encoding and the default width / rate-scaling parameters.
// -----------------------------------------------------------------------------
package voice_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } env_state_e;

    localparam int ENV_WIDTH_DEF  = 8;
    localparam int RATE_SHIFT_DEF = 4;

endpackage

// File: rtl/voice_envelope_if.sv
// -----------------------------------------------------------------------------
// voice_envelope_if
// Bundles the per-voice envelope controls and outputs.
//   master : drives en, gate, attack, decay, sustain, rel_rate, voice_in;
//            receives env_level, sample_out, active.
//   slave  : the envelope generator side (mirror of master).
// The release rate is named rel_rate because "release" is a reserved word.
// -----------------------------------------------------------------------------
interface voice_envelope_if
    import voice_pkg::*;
#(
    parameter int ENV_WIDTH = ENV_WIDTH_DEF
);

    logic                 en;
    logic                 gate;
    logic [3:0]           attack;
    logic [3:0]           decay;
    logic [3:0]           sustain;
    logic [3:0]           rel_rate;
    logic                 voice_in;
    logic [ENV_WIDTH-1:0] env_level;
    logic [ENV_WIDTH-1:0] sample_out;
    logic                 active;

    modport master (
        output en, gate, attack, decay, sustain, rel_rate, voice_in,
        input  env_level, sample_out, active
    );

    modport slave (
        input  en, gate, attack, decay, sustain, rel_rate, voice_in,
        output env_level, sample_out, active
    );

endinterface

// File: rtl/voice_envelope_prescaler.sv
// -----------------------------------------------------------------------------
// env_prescaler
// Counts sample-enable cycles and emits a one-cycle step every
// (rate_i+1) << RATE_SHIFT enabled cycles while run_i is high.
//   clk, rst_n : clock, synchronous active-low reset
//   en_i       : sample enable; the counter only moves on enabled cycles
//   clear_i    : the owning FSM has just changed state; count restarts at 0
//   run_i      : counting allowed (low -> counter held at 0)
//   rate_i     : 4-bit rate of the current envelope phase
//   step_o     : step strobe, valid in the enabled cycle it is raised
// -----------------------------------------------------------------------------
module env_prescaler
    import voice_pkg::*;
#(
    parameter int RATE_SHIFT = RATE_SHIFT_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_i,
    input  logic       clear_i,
    input  logic       run_i,
    input  logic [3:0] rate_i,
    output logic       step_o
);

    localparam int CW = 4 + RATE_SHIFT;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [CW-1:0] cnt_eff;
    logic [CW-1:0] limit;
    logic [CW:0]   period;

    always_comb begin
        period  = (CW+1)'(rate_i) + (CW+1)'(1);
        limit   = CW'((period << RATE_SHIFT) - (CW+1)'(1));
        // clear_i is a registered flag that stays up until the next enabled
        // cycle, so the count is treated as zero there instead of being
        // wiped one cycle early.
        cnt_eff = clear_i ? '0 : cnt_q;
        // >= so that lowering the rate mid-phase fires on the next en cycle
        step_o  = en_i && run_i && (cnt_eff >= limit);
        cnt_d   = cnt_q;
        if (en_i) begin
            if (!run_i || step_o) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_eff + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/voice_envelope.sv
// -----------------------------------------------------------------------------
// voice_envelope
// ADSR envelope generator and amplitude gate following the pulse oscillator.
//   clk, rst_n : clock, synchronous active-low reset
//   env_bus    : slave side of voice_envelope_if
//       en         sample enable shared with the oscillator
//       gate       note on / off
//       attack, decay, rel_rate : phase rates (0 = fastest)
//       sustain    sustain level, replicated up to ENV_WIDTH
//       voice_in   oscillator waveform bit
//       env_level  current envelope level (registered)
//       sample_out voice_in ? previous env_level : 0 (registered)
//       active     state is not IDLE
// -----------------------------------------------------------------------------
module voice_envelope
    import voice_pkg::*;
#(
    parameter int ENV_WIDTH  = ENV_WIDTH_DEF,
    parameter int RATE_SHIFT = RATE_SHIFT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    voice_envelope_if.slave   env_bus
);

    localparam logic [ENV_WIDTH-1:0] MAX = '1;

    function automatic logic [ENV_WIDTH-1:0] sat_inc(input logic [ENV_WIDTH-1:0] v);
        return (v == MAX) ? MAX : v + ENV_WIDTH'(1);
    endfunction

    function automatic logic [ENV_WIDTH-1:0] sat_dec(input logic [ENV_WIDTH-1:0] v);
        return (v == '0) ? '0 : v - ENV_WIDTH'(1);
    endfunction

    // MSB-aligned replication of the 4-bit sustain nibble (4'hA -> 8'hAA).
    function automatic logic [ENV_WIDTH-1:0] expand_sus(input logic [3:0] s);
        logic [ENV_WIDTH-1:0] r;
        for (int i = 0; i < ENV_WIDTH; i++) begin
            r[i] = s[3 - ((ENV_WIDTH - 1 - i) % 4)];
        end
        return r;
    endfunction

    env_state_e           state_q;
    logic [ENV_WIDTH-1:0] level_q;
    logic [ENV_WIDTH-1:0] sample_q;
    logic                 gate_q;
    logic                 restart_q;
    logic                 step;
    logic                 run;
    logic [3:0]           rate_sel;
    logic [ENV_WIDTH-1:0] sus;
    logic [ENV_WIDTH-1:0] level_up;
    logic [ENV_WIDTH-1:0] level_dn;

    always_comb begin
        rate_sel = env_bus.rel_rate;
        unique case (state_q)
            ATTACK:  rate_sel = env_bus.attack;
            DECAY:   rate_sel = env_bus.decay;
            default: rate_sel = env_bus.rel_rate;
        endcase
        run      = (state_q == ATTACK) || (state_q == DECAY) || (state_q == RELEASE);
        sus      = expand_sus(env_bus.sustain);
        level_up = sat_inc(level_q);
        level_dn = sat_dec(level_q);
    end

    env_prescaler #(
        .RATE_SHIFT (RATE_SHIFT)
    ) u_prescaler (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (env_bus.en),
        .clear_i (restart_q),
        .run_i   (run),
        .rate_i  (rate_sel),
        .step_o  (step)
    );

    // Edge-driven transitions need an explicit counter restart; transitions
    // taken on a step already leave the prescaler at zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            level_q   <= '0;
            sample_q  <= '0;
            gate_q    <= 1'b0;
            restart_q <= 1'b0;
        end else if (env_bus.en) begin
            gate_q    <= env_bus.gate;
            sample_q  <= env_bus.voice_in ? level_q : '0;
            restart_q <= 1'b0;
            if (env_bus.gate && !gate_q) begin
                state_q   <= ATTACK;
                restart_q <= 1'b1;
            end else if (!env_bus.gate && gate_q && (state_q != IDLE)) begin
                state_q   <= RELEASE;
                restart_q <= 1'b1;
            end else if (step) begin
                unique case (state_q)
                    ATTACK: begin
                        level_q <= level_up;
                        if (level_up == MAX) state_q <= DECAY;
                    end
                    DECAY: begin
                        if (level_q <= sus) begin
                            state_q <= SUSTAIN;
                        end else begin
                            level_q <= level_dn;
                            if (level_dn == sus) state_q <= SUSTAIN;
                        end
                    end
                    RELEASE: begin
                        level_q <= level_dn;
                        if (level_dn == '0) state_q <= IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign env_bus.env_level  = level_q;
    assign env_bus.sample_out = sample_q;
    assign env_bus.active     = (state_q != IDLE);

endmodule
